// File: rtl/vector_issue_checker.sv
// vector_issue_checker: multi-lane issue checker for the vector dispatch path.
// Checks each issued instruction against per-FU legal micro-op sets, the
// FXP-support mode and the bubble encoding. It also shadows downstream queue
// occupancy. Errors are reported as a registered pulse, a sticky first-error
// capture, a saturating counter and a threshold interrupt.

// FU encodings normally come from params.sv; these defaults apply only when it
// has not already been read.
`ifndef MEM_FU
`define MEM_FU 2'd0
`endif
`ifndef INT_FU
`define INT_FU 2'd1
`endif
`ifndef FP_FU
`define FP_FU 2'd2
`endif
`ifndef FXP_FU
`define FXP_FU 2'd3
`endif

package vector_issue_pkg;

  localparam logic [1:0] FU_MEM = `MEM_FU;
  localparam logic [1:0] FU_INT = `INT_FU;
  localparam logic [1:0] FU_FP  = `FP_FU;
  localparam logic [1:0] FU_FXP = `FXP_FU;

  localparam logic [6:0] BUBBLE_OP = 7'h7F;

  // Fields of the dispatched instruction that this checker looks at.
  typedef struct packed {
    logic [1:0] fu;
    logic [6:0] microop;
    logic       reconfigure;
  } to_vector;

  typedef enum logic [2:0] {
    ERR_NONE   = 3'd0,
    ERR_MEM    = 3'd1,
    ERR_FP     = 3'd2,
    ERR_INT    = 3'd3,
    ERR_FXP    = 3'd4,
    ERR_BUBBLE = 3'd5,
    ERR_OVF    = 3'd6,
    ERR_UDF    = 3'd7
  } err_code_e;

endpackage

module vector_issue_checker
  import vector_issue_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int QUEUE_DEPTH = 8,
  parameter int CNT_W       = 16,
  parameter int FXP_ALLOWED = 0,
  localparam int LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1,
  localparam int OCC_W      = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic     [NUM_LANES-1:0]       valid_in,
  input  to_vector [NUM_LANES-1:0]       instr_in,
  input  logic                           pop,
  input  logic                           clr,
  input  logic     [CNT_W-1:0]           irq_thresh,
  output logic                           err_valid,
  output logic     [2:0]                 err_code,
  output logic     [LANE_W-1:0]          err_lane,
  output logic                           first_valid,
  output logic     [2:0]                 first_code,
  output logic     [LANE_W-1:0]          first_lane,
  output logic     [6:0]                 first_microop,
  output logic     [CNT_W-1:0]           err_count,
  output logic     [OCC_W-1:0]           occupancy,
  output logic                           irq
);

  localparam int PUSH_W = $clog2(NUM_LANES + 1);
  localparam int INC_W  = $clog2(NUM_LANES + 2);
  localparam int SUM_W  = $clog2(QUEUE_DEPTH + NUM_LANES + 1) + 1;
  localparam int CSUM_W = CNT_W + INC_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Legal micro-op sets per functional unit.
  function automatic logic mem_legal(input logic [6:0] op);
    case (op)
      7'h00, 7'h04, 7'h08, 7'h20, 7'h24, 7'h28, 7'h30, 7'h34, 7'h38,
      7'h40, 7'h41, 7'h42, 7'h44, 7'h46, 7'h48, 7'h49, 7'h4A, 7'h53,
      7'h60, 7'h61, 7'h62, 7'h64, 7'h66, 7'h68, 7'h69, 7'h6A,
      7'h70, 7'h71, 7'h72, 7'h73, 7'h74, 7'h76, 7'h78, 7'h79, 7'h7A:
        mem_legal = 1'b1;
      default:
        mem_legal = 1'b0;
    endcase
  endfunction

  function automatic logic int_legal(input logic [6:0] op);
    int_legal = (op >= 7'h01 && op <= 7'h1E) ||
                (op >= 7'h20 && op <= 7'h23) ||
                (op >= 7'h40 && op <= 7'h43);
  endfunction

  function automatic logic fp_legal(input logic [6:0] op);
    fp_legal = (op >= 7'h01 && op <= 7'h03);
  endfunction

  // State registers
  logic                 err_valid_q,     err_valid_d;
  logic [2:0]           err_code_q,      err_code_d;
  logic [LANE_W-1:0]    err_lane_q,      err_lane_d;
  logic                 first_valid_q,   first_valid_d;
  logic [2:0]           first_code_q,    first_code_d;
  logic [LANE_W-1:0]    first_lane_q,    first_lane_d;
  logic [6:0]           first_microop_q, first_microop_d;
  logic [CNT_W-1:0]     err_count_q,     err_count_d;
  logic [OCC_W-1:0]     occupancy_q,     occupancy_d;
  logic                 irq_q,           irq_d;

  // Combinational intermediates
  logic [NUM_LANES-1:0] lane_err;
  logic [2:0]           lane_code [NUM_LANES];
  logic [PUSH_W-1:0]    pushes;
  logic [SUM_W-1:0]     occ_sum;
  logic                 q_ovf;
  logic                 q_udf;
  logic                 q_err;
  logic                 any_err;
  logic [2:0]           rep_code;
  logic [LANE_W-1:0]    rep_lane;
  logic [6:0]           rep_mop;
  logic [INC_W-1:0]     inc;
  logic [CNT_W-1:0]     cnt_base;
  logic [CSUM_W-1:0]    cnt_sum;

  // Per-lane legality check, in priority order: bubble, unsupported FXP,
  // reconfigure bypass, then the FU-specific legal set.
  always_comb begin
    // NOTE: every signal gets a default before any branch so that no path can infer a latch.
    lane_err = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      lane_code[l] = ERR_NONE;
      if (valid_in[l]) begin
        if (instr_in[l].microop == BUBBLE_OP) begin
          lane_err[l]  = 1'b1;
          lane_code[l] = ERR_BUBBLE;
        end else if (instr_in[l].fu == FU_FXP && FXP_ALLOWED == 0) begin
          lane_err[l]  = 1'b1;
          lane_code[l] = ERR_FXP;
        end else if (!instr_in[l].reconfigure) begin
          if (instr_in[l].fu == FU_MEM && !mem_legal(instr_in[l].microop)) begin
            lane_err[l]  = 1'b1;
            lane_code[l] = ERR_MEM;
          end else if (instr_in[l].fu == FU_FP && !fp_legal(instr_in[l].microop)) begin
            lane_err[l]  = 1'b1;
            lane_code[l] = ERR_FP;
          end else if (instr_in[l].fu == FU_INT && !int_legal(instr_in[l].microop)) begin
            lane_err[l]  = 1'b1;
            lane_code[l] = ERR_INT;
          end
        end
      end
    end
  end

  // Shadow queue: every valid lane is a push, whether legal or not. The
  // occupancy clamps at empty and at full.
  always_comb begin
    pushes      = PUSH_W'($countones(valid_in));
    q_ovf       = 1'b0;
    q_udf       = 1'b0;
    occ_sum     = SUM_W'(occupancy_q) + SUM_W'(pushes);
    occupancy_d = occupancy_q;
    if (pop && occupancy_q == '0 && pushes == '0) begin
      q_udf       = 1'b1;
      occupancy_d = '0;
    end else begin
      occ_sum = occ_sum - SUM_W'(pop);
      if (occ_sum > SUM_W'(QUEUE_DEPTH)) begin
        q_ovf       = 1'b1;
        occupancy_d = OCC_W'(QUEUE_DEPTH);
      end else begin
        occupancy_d = OCC_W'(occ_sum);
      end
    end
  end

  // Pick the reported error: lowest erring lane first, queue error otherwise.
  always_comb begin
    q_err    = q_ovf | q_udf;
    any_err  = (|lane_err) | q_err;
    rep_code = q_udf ? ERR_UDF : ERR_OVF;
    rep_lane = '0;
    rep_mop  = '0;
    for (int l = NUM_LANES - 1; l >= 0; l--) begin
      if (lane_err[l]) begin
        rep_code = lane_code[l];
        rep_lane = LANE_W'(l);
        rep_mop  = instr_in[l].microop;
      end
    end
  end

  // Next-state for the report pulse, the saturating counter, the irq level
  // and the first-error capture. An error in a clr cycle survives the clear.
  always_comb begin
    err_valid_d = any_err;
    err_code_d  = any_err ? rep_code : err_code_q;
    err_lane_d  = any_err ? rep_lane : err_lane_q;

    inc         = INC_W'($countones(lane_err)) + INC_W'(q_err);
    cnt_base    = clr ? '0 : err_count_q;
    cnt_sum     = CSUM_W'(cnt_base) + CSUM_W'(inc);
    err_count_d = (cnt_sum > CSUM_W'(CNT_MAX)) ? CNT_MAX : cnt_sum[CNT_W-1:0];
    irq_d       = (err_count_d >= irq_thresh) && (irq_thresh != '0);

    first_valid_d   = clr ? 1'b0 : first_valid_q;
    first_code_d    = clr ? 3'd0 : first_code_q;
    first_lane_d    = clr ? '0   : first_lane_q;
    first_microop_d = clr ? 7'd0 : first_microop_q;
    if (!first_valid_d && any_err) begin
      first_valid_d   = 1'b1;
      first_code_d    = rep_code;
      first_lane_d    = rep_lane;
      first_microop_d = rep_mop;
    end
  end

  // State update; reset clears everything asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_valid_q     <= 1'b0;
      err_code_q      <= '0;
      err_lane_q      <= '0;
      first_valid_q   <= 1'b0;
      first_code_q    <= '0;
      first_lane_q    <= '0;
      first_microop_q <= '0;
      err_count_q     <= '0;
      occupancy_q     <= '0;
      irq_q           <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      err_valid_q     <= err_valid_d;
      err_code_q      <= err_code_d;
      err_lane_q      <= err_lane_d;
      first_valid_q   <= first_valid_d;
      first_code_q    <= first_code_d;
      first_lane_q    <= first_lane_d;
      first_microop_q <= first_microop_d;
      err_count_q     <= err_count_d;
      occupancy_q     <= occupancy_d;
      irq_q           <= irq_d;
    end
  end

  assign err_valid     = err_valid_q;
  assign err_code      = err_code_q;
  assign err_lane      = err_lane_q;
  assign first_valid   = first_valid_q;
  assign first_code    = first_code_q;
  assign first_lane    = first_lane_q;
  assign first_microop = first_microop_q;
  assign err_count     = err_count_q;
  assign occupancy     = occupancy_q;
  assign irq           = irq_q;

endmodule
